// File: rtl/console_detect.sv
// Power-on console probe: grounds CIRAM /CE and /A13 for a while, votes PPU A13 against /A13
// to spot consoles that decode CIRAM themselves, and classifies the video region by frame period.
module console_detect #(
  parameter int unsigned INIT_CYCLES  = 15,
  parameter int unsigned SAMPLES      = 2,
  parameter int unsigned MISMATCH_MIN = 1,
  parameter int unsigned FRAME_W      = 17,
  parameter int unsigned NTSC_MAX     = 31000,
  parameter int unsigned PAL_MAX      = 34400
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       ppu_rd_evt,
  input  logic       ppu_a13,
  input  logic       ppu_not_a13,
  input  logic       frame_evt,
  output logic       init_active,
  output logic       detect_done,
  output logic       new_dendy,
  output logic [1:0] region,
  output logic       region_valid
);

  typedef enum logic [1:0] {StInit, StVote, StDone} state_e;

  localparam logic [7:0]         InitLoad = 8'(INIT_CYCLES - 1);
  localparam logic [3:0]         SampFull = 4'(SAMPLES);
  localparam logic [FRAME_W-1:0] FrameMax = '1;

  state_e             state_q;
  logic [7:0]         init_cnt_q;
  logic [3:0]         lo_cnt_q, hi_cnt_q;
  logic [4:0]         mis_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic               frame_seen_q;

  logic               bucket_open, sample_mis, take;
  logic [3:0]         lo_cnt_d, hi_cnt_d;
  logic [4:0]         mis_cnt_d;
  logic               vote_close;
  logic [1:0]         frame_cls;

  // A read only counts while its level bucket still has room; full-bucket reads are dropped.
  always_comb begin
    bucket_open = ppu_a13 ? (hi_cnt_q != SampFull) : (lo_cnt_q != SampFull);
    sample_mis  = (ppu_not_a13 == ppu_a13);
    take        = (state_q == StVote) && ppu_rd_evt && bucket_open;
    lo_cnt_d    = lo_cnt_q + {3'b000, take & ~ppu_a13};
    hi_cnt_d    = hi_cnt_q + {3'b000, take & ppu_a13};
    mis_cnt_d   = mis_cnt_q + {4'b0000, take & sample_mis & (mis_cnt_q != 5'h1f)};
    vote_close  = take && (lo_cnt_d == SampFull) && (hi_cnt_d == SampFull);
  end

  // A saturated counter means the period is unknown rather than very long.
  always_comb begin
    if (frame_cnt_q == FrameMax) begin
      frame_cls = 2'b11;
    end else if (32'(frame_cnt_q) <= NTSC_MAX) begin
      frame_cls = 2'b00;
    end else if (32'(frame_cnt_q) <= PAL_MAX) begin
      frame_cls = 2'b01;
    end else begin
      frame_cls = 2'b10;
    end
  end

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      state_q      <= StInit;
      init_cnt_q   <= InitLoad;
      lo_cnt_q     <= '0;
      hi_cnt_q     <= '0;
      mis_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_seen_q <= 1'b0;
      init_active  <= 1'b1;
      detect_done  <= 1'b0;
      new_dendy    <= 1'b0;
      region       <= 2'b11;
      region_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == 8'd0) begin
            state_q     <= StVote;
            init_active <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q - 8'd1;
          end
        end
        StVote: begin
          lo_cnt_q  <= lo_cnt_d;
          hi_cnt_q  <= hi_cnt_d;
          mis_cnt_q <= mis_cnt_d;
          if (vote_close) begin
            state_q     <= StDone;
            detect_done <= 1'b1;
            new_dendy   <= (32'(mis_cnt_d) >= MISMATCH_MIN);
          end
        end
        StDone: state_q <= StDone;
        default: state_q <= StInit;
      endcase

      // The first frame pulse only opens the measurement window.
      if (state_q != StInit) begin
        if (frame_evt) begin
          frame_cnt_q  <= '0;
          frame_seen_q <= 1'b1;
          if (frame_seen_q) begin
            region       <= frame_cls;
            region_valid <= (frame_cls == region) && (frame_cls != 2'b11);
          end
        end else if (frame_cnt_q != FrameMax) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
